// File: rtl/mux_ctrl_pkg.sv
// Shared defaults and sizing helper for the mux select control block.
// Pure declarations; no logic, no latency.
package mux_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int AUTO_PERIOD_DEF     = 8;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-FF synchroniser, stability-count debouncer and rising-edge detector for a raw button.
// dout follows din DEBOUNCE_CYCLES+2 edges after din settles; rise is combinational with dout's update edge.
module debounce_filter
  import mux_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q;
  logic          clean_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any sample agreeing with the current clean level restarts the stability count.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    if (sync2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      clean_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = clean_q;
  assign rise = clean_d & ~clean_q;

endmodule

// File: rtl/mux_select_ctrl.sv
// Generates the registered 2:1 mux select: toggles on each clean button press or every AUTO_PERIOD cycles in auto mode.
// select and toggle_pulse update on the same edge as the triggering event; no backpressure.
module mux_select_ctrl
  import mux_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int   AUTO_PERIOD     = AUTO_PERIOD_DEF,
  parameter logic SEL_RESET       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic auto_en,
  output logic select,
  output logic toggle_pulse,
  output logic btn_clean
);

  localparam int PW = cnt_width(AUTO_PERIOD - 1);

  logic          press;
  logic          auto_evt;
  logic          tog;
  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic          sel_q;
  logic          sel_d;
  logic          pulse_q;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (btn),
    .dout (btn_clean),
    .rise (press)
  );

  assign auto_evt = auto_en & (pcnt_q == PW'(AUTO_PERIOD - 1));
  // A press coinciding with an auto event collapses into a single flip.
  assign tog      = press | auto_evt;

  always_comb begin
    pcnt_d = '0;
    if (auto_en && !auto_evt) begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  assign sel_d = tog ? ~sel_q : sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q  <= '0;
      sel_q   <= SEL_RESET;
      pulse_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      sel_q   <= sel_d;
      pulse_q <= tog;
    end
  end

  assign select       = sel_q;
  assign toggle_pulse = pulse_q;

endmodule

// File: tb/tb_mux_select_ctrl.sv
// Bench for mux_select_ctrl feeding a 2:1 byte mux; expected toggles are queued with their due cycle.
module tb_mux_select_ctrl;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       btn     = 1'b0;
  logic       auto_en = 1'b0;
  logic       select;
  logic       toggle_pulse;
  logic       btn_clean;
  logic [7:0] a_dat   = 8'h00;
  logic [7:0] b_dat   = 8'h00;
  logic [7:0] y_dat;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int   cyc;
    logic sel;
  } ev_t;

  ev_t  q[$];
  logic exp_sel = 1'b0;
  logic cur_exp = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mux_select_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (8),
    .SEL_RESET      (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .auto_en     (auto_en),
    .select      (select),
    .toggle_pulse(toggle_pulse),
    .btn_clean   (btn_clean)
  );

  // Downstream 2:1 mux driven by the generated select.
  assign y_dat = select ? b_dat : a_dat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("@@@ FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    a_dat = 8'($urandom);
    b_dat = 8'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_tog(input int at);
    exp_sel = ~exp_sel;
    q.push_back('{cyc: at, sel: exp_sel});
  endtask

  task automatic do_reset(input logic ae);
    reset   = 1'b1;
    btn     = 1'b0;
    auto_en = ae;
    q.delete();
    exp_sel = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // Per-cycle monitor: pulse only on the due cycle, select and mux output track the expected level.
  always @(negedge clk) begin
    logic exp_p;
    if (reset) begin
      cur_exp = 1'b0;
    end else begin
      exp_p = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        cur_exp = q[0].sel;
        exp_p   = 1'b1;
        void'(q.pop_front());
      end
      chk("pulse", toggle_pulse, exp_p);
      chk("select", select, cur_exp);
      chk("mux_y", y_dat, cur_exp ? b_dat : a_dat);
    end
  end

  initial begin
    #200000;
    $display("@@@ FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r;

    // Reset state and idle stability.
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_select", select, 1'b0);
    chk("rst_clean", btn_clean, 1'b0);
    chk("rst_pulse", toggle_pulse, 1'b0);
    repeat (20) tick();
    chk("idle_select", select, 1'b0);
    chk("idle_clean", btn_clean, 1'b0);

    // Clean press: debounced level and toggle 6 edges after the first sampling edge.
    n   = cyc;
    btn = 1'b1;
    push_tog(n + 6);
    repeat (5) tick();
    chk("clean_pre", btn_clean, 1'b0);
    tick();
    chk("clean_rise", btn_clean, 1'b1);
    chk("press_sel", select, 1'b1);
    repeat (4) tick();
    btn = 1'b0;
    repeat (12) tick();
    chk("clean_fall", btn_clean, 1'b0);

    // Bouncing input never reaches the debounced level.
    btn = 1'b1; repeat (2) tick();
    btn = 1'b0; tick();
    btn = 1'b1; repeat (3) tick();
    btn = 1'b0; repeat (10) tick();
    chk("bounce_clean", btn_clean, 1'b0);
    n   = cyc;
    btn = 1'b1;
    push_tog(n + 6);
    repeat (8) tick();
    btn = 1'b0;
    repeat (12) tick();
    chk("press2_sel", select, 1'b0);

    // Auto mode from reset: toggles every 8 edges.
    do_reset(1'b1);
    r = cyc;
    push_tog(r + 8);
    push_tog(r + 16);
    push_tog(r + 24);
    wait_until(r + 24);
    chk("auto_sel24", select, 1'b1);
    auto_en = 1'b0;
    repeat (10) tick();

    // Auto gap restarts a full period on re-enable.
    do_reset(1'b1);
    r = cyc;
    push_tog(r + 8);
    wait_until(r + 12);
    auto_en = 1'b0;
    wait_until(r + 14);
    auto_en = 1'b1;
    push_tog(r + 22);
    wait_until(r + 22);
    chk("auto_gap_sel", select, 1'b0);
    auto_en = 1'b0;
    repeat (10) tick();

    // Press landing on an auto event yields a single flip.
    do_reset(1'b1);
    r = cyc;
    push_tog(r + 8);
    wait_until(r + 10);
    btn = 1'b1;
    push_tog(r + 16);
    wait_until(r + 16);
    chk("coinc_clean", btn_clean, 1'b1);
    chk("coinc_sel", select, 1'b0);
    tick();
    chk("coinc_one", toggle_pulse, 1'b0);
    wait_until(r + 20);
    auto_en = 1'b0;
    btn     = 1'b0;
    repeat (12) tick();

    // Reset in the middle of a debounce restarts the full latency.
    do_reset(1'b0);
    n   = cyc;
    btn = 1'b1;
    push_tog(n + 6);
    repeat (8) tick();
    btn = 1'b0;
    repeat (12) tick();
    chk("pre_mid_sel", select, 1'b1);
    btn = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    q.delete();
    exp_sel = 1'b0;
    repeat (2) tick();
    chk("mid_rst_sel", select, 1'b0);
    chk("mid_rst_clean", btn_clean, 1'b0);
    chk("mid_rst_pulse", toggle_pulse, 1'b0);
    reset = 1'b0;
    r = cyc;
    push_tog(r + 6);
    repeat (5) tick();
    chk("post_rst_pre", btn_clean, 1'b0);
    tick();
    chk("post_rst_clean", btn_clean, 1'b1);
    chk("post_rst_sel", select, 1'b1);
    btn = 1'b0;
    repeat (12) tick();

    chk("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
